display_sequencer: RTL and testbench
====================================

Name: display_sequencer

Overview:
- Controller for the 4-digit BCD visualization stage.
- Accepts drawn BINGO numbers (2-digit packed BCD) from the game core over a valid/ready handshake.
- Sequences them onto the display pair 1 number/enable inputs, with a blanking gap and a hold time; keeps the previous number on display pair 2.
- Blinks pair 1 while a bingo is flagged.
- Sits between the game FSM and the visualization block.

Parameters:
- HOLD_CYCLES, 50_000_000: cycles a new number is shown before the next is accepted (min 1).
- BLANK_CYCLES, 5_000_000: cycles pair 1 is blanked before a new number appears (min 1).
- BLINK_HALF, 12_500_000: half-period of the bingo blink, in cycles (min 1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  new number offered
- in_ready  out  1  sequencer can accept a number
- in_bcd  in  8  [7:4] tens, [3:0] units, BCD
- clear  in  1  synchronous game clear
- bingo  in  1  level; blink the current number
- number_1  out  8  current number, to visualization
- number_2  out  8  previous number, to visualization
- enable_displays_1  out  1  pair 1 enable
- enable_displays_2  out  1  pair 2 enable
- busy  out  1  state != IDLE

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. rst has priority over clear; clear has priority over everything else.
- Reset/clear values:
  - state=IDLE
  - number_1=8'hFF, number_2=8'hFF
  - enable_displays_1=0, enable_displays_2=0
  - hist_valid=0, all counters 0
  - in_ready=1 (combinational), busy=0
- in_ready = (state==IDLE) && !bingo. An accept occurs on a clk edge where in_valid && in_ready.
- Sanitize: each nibble of in_bcd >9 is replaced by 4'hF (blank code) before capture.
- States:
  - IDLE. On accept:
    - number_1 <= sanitized in_bcd; number_2 <= old number_1.
    - enable_displays_2 <= hist_valid; hist_valid <= 1 once number_1 holds a real number, i.e. from the second accept onward.
    - enable_displays_1 <= 0; counter <= BLANK_CYCLES-1; go to BLANK.
  - BLANK: counter decrements each cycle. At 0: enable_displays_1 <= 1, counter <= HOLD_CYCLES-1, go to SHOW. Pair 1 is dark for exactly BLANK_CYCLES cycles.
  - SHOW: counter decrements. At 0, go to IDLE. enable_displays_1 stays 1 in IDLE.
- The first valid number becomes visible BLANK_CYCLES+1 edges after the accept edge. in_ready returns BLANK_CYCLES+HOLD_CYCLES+1 edges after the accept edge.
- Bingo blink (state IDLE or SHOW, and hist_valid or number_1 != 8'hFF):
  - blink counter runs; enable_displays_1 toggles every BLINK_HALF cycles, starting with 0 on the first edge with bingo=1.
  - SHOW still times out normally.
  - On bingo deassert: enable_displays_1 <= 1 next edge; blink counter <= 0.
- bingo in BLANK: no effect until BLANK ends.
- bingo in IDLE before any number has been accepted: no blink, outputs stay blank.
- in_valid held during BLANK/SHOW: not accepted, not lost. The source must hold it (AXI-style: in_bcd stable while in_valid && !in_ready).
- Back-to-back: in_valid high continuously gives one accept per BLANK_CYCLES+HOLD_CYCLES+1 cycles.
- clear mid-sequence (any state): immediate return to the reset values next edge. A simultaneous in_valid is ignored.
- Counter width: $clog2 of max(HOLD_CYCLES, BLANK_CYCLES, BLINK_HALF)+1. No wrap; counters are loaded, never free-run, except the blink counter, which wraps at BLINK_HALF-1.

Optional Feature:
- Macro: DISP_BLANK_GAP_EN.
- Defined: BLANK state and BLANK_CYCLES behave as above.
- Undefined:
  - BLANK state is not built; an accept goes directly to SHOW with enable_displays_1 <= 1 and counter <= HOLD_CYCLES-1.
  - First valid number is visible 1 edge after accept; in_ready returns HOLD_CYCLES+1 edges after accept.
  - BLANK_CYCLES is unused.

Decomposition:
- Package disp_pkg:
  - state enum (IDLE, BLANK, SHOW)
  - BLANK_NIBBLE=4'hF, BLANK_BYTE=8'hFF
  - function bcd_sanitize(8-bit) -> 8-bit
- Sub-module cycle_timer:
  - loadable down-counter with load, load_val, done (count==0), parameter WIDTH.
  - One instance for BLANK/SHOW timing, one for the blink.

Test Plan (HOLD_CYCLES=4, BLANK_CYCLES=2, BLINK_HALF=3):
- Reset then accept 8'h42 -> in_ready low; en1=0 for 2 cycles, then en1=1 with number_1=8'h42 for 4 cycles; en2=0; in_ready high again 7 edges after accept.
- Accept 8'h07 then 8'h75 (in_valid held) -> second accept exactly 7 cycles after the first; number_1=8'h75, number_2=8'h07, en2=1.
- Accept 8'hA3 -> number_1=8'hF3.
- Accept 8'hB0 -> number_1=8'hF0.
- After 8'h42 is shown and IDLE is reached, bingo=1 for 12 cycles -> en1 pattern 000111000111; in_ready=0 throughout; en1=1 the edge after bingo drops.
- clear asserted in SHOW together with in_valid -> next edge: numbers 8'hFF, en1=en2=0, state IDLE, no accept.
- Build without DISP_BLANK_GAP_EN, accept 8'h11 -> en1=1 with number_1=8'h11 one edge after accept; in_ready high 5 edges after accept.

Source files
------------

// File: rtl/display_sequencer_pkg.sv
// Shared types and helpers for the display sequencer: FSM states, blank codes
// and the BCD sanitizer used when capturing a drawn number.
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_e;

    localparam logic [3:0] BLANK_NIBBLE = 4'hF;
    localparam logic [7:0] BLANK_BYTE   = 8'hFF;

    // Any nibble outside 0..9 becomes the blank code so the digit stays dark.
    function automatic logic [7:0] bcd_sanitize(input logic [7:0] value);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = (value[7:4] > 4'd9) ? BLANK_NIBBLE : value[7:4];
        units = (value[3:0] > 4'd9) ? BLANK_NIBBLE : value[3:0];
        return {tens, units};
    endfunction

endpackage

// File: rtl/display_sequencer_cycle_timer.sv
// Loadable down-counter that saturates at zero; done is high while the count is zero.
module cycle_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: a load wins over a decrement; the count never wraps below zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != {WIDTH{1'b0}})) begin
            count_d = count_q - WIDTH'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= {WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == {WIDTH{1'b0}});

endmodule

// File: rtl/display_sequencer.sv
// Sequences drawn BINGO numbers onto display pairs 1/2 with blank gap, hold time
// and bingo blink. Optional blank gap is built when DISP_BLANK_GAP_EN is defined.
module display_sequencer
    import disp_pkg::*;
#(
    parameter int HOLD_CYCLES  = 50_000_000,
    parameter int BLANK_CYCLES = 5_000_000,
    parameter int BLINK_HALF   = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_bcd,
    input  logic       clear,
    input  logic       bingo,
    output logic [7:0] number_1,
    output logic [7:0] number_2,
    output logic       enable_displays_1,
    output logic       enable_displays_2,
    output logic       busy
);

    localparam int SEQ_MAX = (HOLD_CYCLES > BLANK_CYCLES) ? HOLD_CYCLES : BLANK_CYCLES;
    localparam int CNT_MAX = (SEQ_MAX > BLINK_HALF) ? SEQ_MAX : BLINK_HALF;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] BLINK_LOAD = CW'(BLINK_HALF - 1);
`ifdef DISP_BLANK_GAP_EN
    localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES - 1);
`endif

    state_e     state_q, state_d;
    logic [7:0] number_1_q, number_1_d;
    logic [7:0] number_2_q, number_2_d;
    logic       en1_q, en1_d;
    logic       en2_q, en2_d;
    logic       hist_valid_q, hist_valid_d;
    logic       blink_active_q, blink_active_d;

    logic          accept;
    logic          blink_ok;
    logic          seq_load, seq_dec, seq_done;
    logic [CW-1:0] seq_load_val;
    logic          blink_load, blink_dec, blink_done;
    logic [CW-1:0] blink_load_val;

    assign in_ready = (state_q == IDLE) && !bingo;
    assign accept   = in_valid && in_ready;
    assign blink_ok = ((state_q == IDLE) || (state_q == SHOW)) &&
                      (hist_valid_q || (number_1_q != BLANK_BYTE));

    cycle_timer #(.WIDTH(CW)) u_seq_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (seq_load),
        .load_val (seq_load_val),
        .dec      (seq_dec),
        .done     (seq_done)
    );

    cycle_timer #(.WIDTH(CW)) u_blink_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (blink_load),
        .load_val (blink_load_val),
        .dec      (blink_dec),
        .done     (blink_done)
    );

    // Next-state, capture and blink control.
    always_comb begin
        state_d        = state_q;
        number_1_d     = number_1_q;
        number_2_d     = number_2_q;
        en1_d          = en1_q;
        en2_d          = en2_q;
        hist_valid_d   = hist_valid_q;
        blink_active_d = blink_active_q;
        seq_load       = 1'b0;
        seq_load_val   = {CW{1'b0}};
        seq_dec        = 1'b0;
        blink_load     = 1'b0;
        blink_load_val = {CW{1'b0}};
        blink_dec      = 1'b0;

        if (clear) begin
            state_d        = IDLE;
            number_1_d     = BLANK_BYTE;
            number_2_d     = BLANK_BYTE;
            en1_d          = 1'b0;
            en2_d          = 1'b0;
            hist_valid_d   = 1'b0;
            blink_active_d = 1'b0;
            seq_load       = 1'b1;
            blink_load     = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        number_1_d   = bcd_sanitize(in_bcd);
                        number_2_d   = number_1_q;
                        en2_d        = hist_valid_q;
                        hist_valid_d = 1'b1;
                        seq_load     = 1'b1;
`ifdef DISP_BLANK_GAP_EN
                        en1_d        = 1'b0;
                        seq_load_val = BLANK_LOAD;
                        state_d      = BLANK;
`else
                        en1_d        = 1'b1;
                        seq_load_val = HOLD_LOAD;
                        state_d      = SHOW;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
`ifdef DISP_BLANK_GAP_EN
                BLANK: begin
                    seq_dec = 1'b1;
                    if (seq_done) begin
                        en1_d        = 1'b1;
                        seq_load     = 1'b1;
                        seq_load_val = HOLD_LOAD;
                        state_d      = SHOW;
                    end else begin
                        state_d = BLANK;
                    end
                end
`endif
                SHOW: begin
                    seq_dec = 1'b1;
                    if (seq_done) begin
                        state_d = IDLE;
                    end else begin
                        state_d = SHOW;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            // The first bingo edge forces pair 1 dark, then it toggles every BLINK_HALF cycles.
            if (bingo && blink_ok) begin
                if (!blink_active_q) begin
                    en1_d          = 1'b0;
                    blink_active_d = 1'b1;
                    blink_load     = 1'b1;
                    blink_load_val = BLINK_LOAD;
                end else if (blink_done) begin
                    en1_d          = !en1_q;
                    blink_load     = 1'b1;
                    blink_load_val = BLINK_LOAD;
                end else begin
                    blink_dec = 1'b1;
                end
            end else if (blink_active_q) begin
                en1_d          = 1'b1;
                blink_active_d = 1'b0;
                blink_load     = 1'b1;
            end else begin
                blink_active_d = 1'b0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            number_1_q     <= BLANK_BYTE;
            number_2_q     <= BLANK_BYTE;
            en1_q          <= 1'b0;
            en2_q          <= 1'b0;
            hist_valid_q   <= 1'b0;
            blink_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            number_1_q     <= number_1_d;
            number_2_q     <= number_2_d;
            en1_q          <= en1_d;
            en2_q          <= en2_d;
            hist_valid_q   <= hist_valid_d;
            blink_active_q <= blink_active_d;
        end
    end

    assign number_1          = number_1_q;
    assign number_2          = number_2_q;
    assign enable_displays_1 = en1_q;
    assign enable_displays_2 = en2_q;
    assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_display_sequencer.sv
// Scoreboard bench for display_sequencer: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them. Timing adapts to DISP_BLANK_GAP_EN.
module tb_display_sequencer;

    localparam int HOLD = 4;
    localparam int BLNK = 2;
    localparam int HALF = 3;
`ifdef DISP_BLANK_GAP_EN
    localparam int GAP = BLNK;
`else
    localparam int GAP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_bcd;
    logic       clear;
    logic       bingo;
    logic [7:0] number_1;
    logic [7:0] number_2;
    logic       en1;
    logic       en2;
    logic       busy;

    always #5 clk = ~clk;

    display_sequencer #(
        .HOLD_CYCLES  (HOLD),
        .BLANK_CYCLES (BLNK),
        .BLINK_HALF   (HALF)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_bcd            (in_bcd),
        .clear             (clear),
        .bingo             (bingo),
        .number_1          (number_1),
        .number_2          (number_2),
        .enable_displays_1 (en1),
        .enable_displays_2 (en2),
        .busy              (busy)
    );

    typedef struct {
        int         cyc;
        string      name;
        logic [7:0] n1;
        logic [7:0] n2;
        logic       e1;
        logic       e2;
        logic       rdy;
        logic       bsy;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation scheduled for the current cycle.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            tests_run++;
            if (e.cyc != cyc || number_1 !== e.n1 || number_2 !== e.n2 || en1 !== e.e1 ||
                en2 !== e.e2 || in_ready !== e.rdy || busy !== e.bsy) begin
                tests_failed++;
                $display("FAIL %s cyc=%0d(exp %0d): got n1=%h n2=%h en1=%b en2=%b rdy=%b busy=%b, want n1=%h n2=%h en1=%b en2=%b rdy=%b busy=%b",
                         e.name, cyc, e.cyc, number_1, number_2, en1, en2, in_ready, busy,
                         e.n1, e.n2, e.e1, e.e2, e.rdy, e.bsy);
            end
        end
    end

    task automatic push(input string nm, input int c, input logic [7:0] n1, input logic [7:0] n2,
                        input logic e1, input logic e2, input logic rdy, input logic bsy);
        exp_t e;
        e.cyc = c; e.name = nm; e.n1 = n1; e.n2 = n2;
        e.e1 = e1; e.e2 = e2; e.rdy = rdy; e.bsy = bsy;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer bcd now; the accept lands on the next edge and the full sequence is expected.
    task automatic do_accept(input string nm, input logic [7:0] bcd, input logic [7:0] n1,
                             input logic [7:0] n2, input logic e2, input bit keep);
        int a;
        in_valid = 1'b1;
        in_bcd   = bcd;
        a = cyc + 1;
        for (int j = 0; j <= GAP + HOLD; j++) begin
            if (j < GAP)
                push({nm, "_blank"}, a + j, n1, n2, 1'b0, e2, 1'b0, 1'b1);
            else if (j < GAP + HOLD)
                push({nm, "_show"}, a + j, n1, n2, 1'b1, e2, 1'b0, 1'b1);
            else
                push({nm, "_idle"}, a + j, n1, n2, 1'b1, e2, 1'b1, 1'b0);
        end
        tick();
        if (!keep) in_valid = 1'b0;
        repeat (GAP + HOLD) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         b;
        int         a;
        logic [11:0] pat;
        rst = 1'b1; in_valid = 1'b0; in_bcd = 8'h00; clear = 1'b0; bingo = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        push("reset", cyc, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
        push("reset_hold", cyc + 1, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();

        do_accept("acc42", 8'h42, 8'h42, 8'hFF, 1'b0, 1'b0);

        // Bingo for 12 cycles: blink 000111000111, then steady on.
        tick();
        bingo = 1'b1;
        b = cyc;
        pat = 12'b000111000111;
        push("bingo_start", b, 8'h42, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 12; k++)
            push("bingo_blink", b + k, 8'h42, 8'hFF, pat[12-k], 1'b0, (k == 12) ? 1'b1 : 1'b0, 1'b0);
        push("bingo_end", b + 13, 8'h42, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (12) tick();
        bingo = 1'b0;
        tick();

        // Short bingo ending while pair 1 is dark.
        tick();
        bingo = 1'b1;
        b = cyc;
        push("bingo2_start", b, 8'h42, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        push("bingo2_dark", b + 1, 8'h42, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        push("bingo2_drop", b + 2, 8'h42, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
        push("bingo2_on", b + 3, 8'h42, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (2) tick();
        bingo = 1'b0;
        tick();

        // Back-to-back with in_valid held high.
        do_accept("acc07", 8'h07, 8'h07, 8'h42, 1'b1, 1'b1);
        do_accept("acc75", 8'h75, 8'h75, 8'h07, 1'b1, 1'b0);

        // Clear in SHOW together with in_valid.
        in_valid = 1'b1;
        in_bcd   = 8'h55;
        a = cyc + 1;
        for (int j = 0; j < GAP; j++)
            push("clr_blank", a + j, 8'h55, 8'h75, 1'b0, 1'b1, 1'b0, 1'b1);
        push("clr_show", a + GAP, 8'h55, 8'h75, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        repeat (GAP) tick();
        clear = 1'b1;
        push("clr_reset", a + GAP + 1, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
        push("clr_noaccept", a + GAP + 2, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        tick();

        // Bingo before any number: no blink, pair 1 stays dark.
        tick();
        bingo = 1'b1;
        b = cyc;
        for (int k = 0; k < 3; k++)
            push("bingo_empty", b + k, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        push("bingo_empty_drop", b + 3, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
        push("bingo_empty_after", b + 4, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) tick();
        bingo = 1'b0;
        tick();

        // Sanitizing of non-BCD nibbles.
        do_accept("accA3", 8'hA3, 8'hF3, 8'hFF, 1'b0, 1'b0);
        do_accept("accB0", 8'hB0, 8'hF0, 8'hF3, 1'b1, 1'b0);

        repeat (3) tick();
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard: %0d expectations never compared", sb.size());
        end
        if (tests_run < 12) begin
            tests_failed++;
            $display("FAIL coverage: only %0d comparisons ran", tests_run);
        end
        if (tests_failed != 0)
            $display("FAIL summary: %0d failures", tests_failed);
        else
            $display("PASS all checks");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
